ped_request_ctrl: RTL and testbench
===================================

PED_REQUEST_CTRL -- requirements
Module: ped_request_ctrl

Interface
REQ-001 Parameter DEB_TICKS, default 3, consecutive synchronized-high samples required to accept a button press (legal range 1..15).
REQ-002 Parameter LOCKOUT_TICKS, default 100, cycles after pedestrian green ends during which no early request is issued (legal range 1..255).
REQ-003 Reset rst_n is asynchronous, active-low; clock is clk_10Hz; all state is in the clk_10Hz domain.
REQ-004 clk_10Hz  in  1  traffic light clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  traffic light switched on; low means synchronous clear.
REQ-007 btn_l, btn_r  in  1 each  raw asynchronous pedestrian buttons, active high.
REQ-008 car_green  in  1  car FSM in steady green state.
REQ-009 ped_green  in  1  pedestrian green or green-blink active.
REQ-010 req_ack  in  1  light controller accepted early request (countdown started).
REQ-011 req_out  out  1  registered early-green request to light controller.
REQ-012 pending_l, pending_r  out  1 each  "request registered" indicator lamps.
REQ-013 lockout  out  1  high while in LOCKOUT.
REQ-014 req_count  out  8  served-request count, saturating.

Function
REQ-015 Each button passes a 2-flop synchronizer before any other use.
REQ-016 Per-button debounce counter: increments while synced input high, clears to 0 on the first low sample, and stops at DEB_TICKS after acceptance so a held button produces exactly one press event.
REQ-017 A press event occurs on the edge where the counter equals DEB_TICKS-1 and the synced input is high; with DEB_TICKS=3 the pending flag rises on the 5th rising edge counted from the first edge that samples btn high.
REQ-018 A press event sets its side's pending flag, except in state GREEN or while ped_green is high, where the event is discarded.
REQ-019 Both pending flags clear on the first edge sampling ped_green high, in any state.
REQ-020 FSM states: IDLE, PENDING, REQ, WAIT_GREEN, GREEN, LOCKOUT.
REQ-021 IDLE: a press event moves to PENDING.
REQ-022 PENDING: ped_green high moves to GREEN (priority); otherwise car_green high moves to REQ.
REQ-023 REQ: ped_green high moves to GREEN (priority); otherwise req_ack high moves to WAIT_GREEN; otherwise car_green low returns to PENDING.
REQ-024 WAIT_GREEN: ped_green high moves to GREEN.
REQ-025 GREEN: ped_green low moves to LOCKOUT, loads the lockout counter with 0, and increments req_count, saturating at 255.
REQ-026 LOCKOUT: counter increments each cycle; at LOCKOUT_TICKS-1 it exits to PENDING if either pending flag is set, else to IDLE.
REQ-027 Presses during LOCKOUT are latched (REQ-018) but do not issue req_out until exit.
REQ-028 req_out is registered and high exactly while state==REQ, so it rises one edge after car_green is sampled high in PENDING and falls on the edge sampling req_ack.
REQ-029 A natural-cycle ped_green while in IDLE leaves the FSM in IDLE and does not count.
REQ-030 When enable is low on an edge: state returns to IDLE; pending flags, debounce counters, lockout counter and req_out clear; req_count holds its value.
REQ-031 Unused state encodings return to IDLE on the next edge.

Reset
REQ-032 Asserting rst_n low immediately forces state IDLE, req_out=0, pending_l=pending_r=0, lockout=0, req_count=0, and clears synchronizers and all counters, including in the middle of a REQ or LOCKOUT.
REQ-033 After release, the first active edge behaves as IDLE with empty synchronizers.

Verification
REQ-034 btn_l high for 2 cycles, DEB_TICKS=3 -> no pending_l, req_out stays 0.
REQ-035 btn_r held 20 cycles while car_green=1 -> pending_r rises at edge 5 and req_out rises at edge 6; req_ack at edge 10 -> req_out falls at edge 10; ped_green 1 then 0 -> lockout rises, pending_r clears, req_count=1.
REQ-036 Press during LOCKOUT (LOCKOUT_TICKS=100) -> pending set, req_out low for the remaining lockout, then PENDING->REQ once car_green=1.
REQ-037 In REQ, car_green drops before req_ack -> req_out falls next edge; state PENDING; car_green returning -> req_out reasserts.
REQ-038 Press while PENDING and ped_green rises on the same edge -> GREEN, flags 0, press discarded; enable low mid-REQ -> IDLE, req_out 0, req_count unchanged.
REQ-039 256 served requests -> req_count saturates at 255; rst_n pulse mid-LOCKOUT -> all outputs 0 immediately.

Source files
------------

// File: rtl/ped_request_ctrl.sv
// Pedestrian request front-end: synchronizes and debounces both buttons, latches requests and
// asks the light controller for an early pedestrian green, then holds off during a lockout.
module ped_request_ctrl #(
    parameter int unsigned DEB_TICKS     = 3,
    parameter int unsigned LOCKOUT_TICKS = 100
) (
    input  logic       clk_10Hz,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       car_green,
    input  logic       ped_green,
    input  logic       req_ack,
    output logic       req_out,
    output logic       pending_l,
    output logic       pending_r,
    output logic       lockout,
    output logic [7:0] req_count
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PENDING    = 3'd1,
        ST_REQ        = 3'd2,
        ST_WAIT_GREEN = 3'd3,
        ST_GREEN      = 3'd4,
        ST_LOCKOUT    = 3'd5
    } state_t;

    localparam logic [3:0] DEB_MAX   = 4'(DEB_TICKS);
    localparam logic [3:0] DEB_PRE   = 4'(DEB_TICKS - 1);
    localparam logic [7:0] LOCK_LAST = 8'(LOCKOUT_TICKS - 1);
    localparam logic [7:0] CNT_MAX   = 8'd255;

    state_t     state;
    logic [1:0] btn_meta;          // bit 0 = left button, bit 1 = right button
    logic [1:0] btn_sync;
    logic [3:0] deb_cnt [2];
    logic [1:0] press_evt;
    logic [1:0] press_ok;
    logic       any_press;
    logic [7:0] lock_cnt;

    always_ff @(posedge clk_10Hz or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            // NOTE: non-blocking so the second stage captures the first stage's old value.
            btn_meta <= {btn_r, btn_l};
            btn_sync <= btn_meta;
        end
    end

    // Counter parks at DEB_TICKS so a held button yields a single press event.
    always_ff @(posedge clk_10Hz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else if (!enable) begin
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!btn_sync[i])
                    deb_cnt[i] <= '0;
                else if (deb_cnt[i] != DEB_MAX)
                    deb_cnt[i] <= deb_cnt[i] + 4'd1;
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        press_evt = '0;
        for (int i = 0; i < 2; i++)
            press_evt[i] = btn_sync[i] && (deb_cnt[i] == DEB_PRE);
        press_ok  = press_evt & {2{(state != ST_GREEN) && !ped_green}};
        any_press = |press_ok;
    end

    always_ff @(posedge clk_10Hz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_out   <= 1'b0;
            lockout   <= 1'b0;
            pending_l <= 1'b0;
            pending_r <= 1'b0;
            lock_cnt  <= '0;
            req_count <= '0;
        end else if (!enable) begin
            state     <= ST_IDLE;
            req_out   <= 1'b0;
            lockout   <= 1'b0;
            pending_l <= 1'b0;
            pending_r <= 1'b0;
            lock_cnt  <= '0;
        end else begin
            if (ped_green) begin
                pending_l <= 1'b0;
                pending_r <= 1'b0;
            end else begin
                pending_l <= pending_l | press_ok[0];
                pending_r <= pending_r | press_ok[1];
            end

            req_out <= 1'b0;
            lockout <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (any_press) state <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (ped_green) begin
                        state <= ST_GREEN;
                    end else if (car_green) begin
                        state   <= ST_REQ;
                        req_out <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ped_green)
                        state <= ST_GREEN;
                    else if (req_ack)
                        state <= ST_WAIT_GREEN;
                    else if (!car_green)
                        state <= ST_PENDING;
                    else
                        req_out <= 1'b1;
                end
                ST_WAIT_GREEN: begin
                    if (ped_green) state <= ST_GREEN;
                end
                ST_GREEN: begin
                    if (!ped_green) begin
                        state    <= ST_LOCKOUT;
                        lockout  <= 1'b1;
                        lock_cnt <= '0;
                        if (req_count != CNT_MAX) req_count <= req_count + 8'd1;
                    end
                end
                ST_LOCKOUT: begin
                    // A press landing on the exit edge still counts as waiting.
                    if (lock_cnt == LOCK_LAST) begin
                        state <= (pending_l || pending_r || any_press) ? ST_PENDING : ST_IDLE;
                    end else begin
                        lock_cnt <= lock_cnt + 8'd1;
                        lockout  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Bench for ped_request_ctrl: directed scenarios plus randomized traffic, all compared against
// a behavioural model built from run-lengths, a remaining-time lockout and plain state names.
module tb_ped_request_ctrl;

    localparam int DEB  = 3;
    localparam int LOCK = 100;

    logic       clk_10Hz  = 1'b0;
    logic       rst_n     = 1'b1;
    logic       enable    = 1'b1;
    logic       btn_l     = 1'b0;
    logic       btn_r     = 1'b0;
    logic       car_green = 1'b0;
    logic       ped_green = 1'b0;
    logic       req_ack   = 1'b0;
    logic       req_out;
    logic       pending_l;
    logic       pending_r;
    logic       lockout;
    logic [7:0] req_count;
    logic [11:0] dut_vec;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lock_entry = 0;

    ped_request_ctrl #(.DEB_TICKS(DEB), .LOCKOUT_TICKS(LOCK)) dut (
        .clk_10Hz  (clk_10Hz),
        .rst_n     (rst_n),
        .enable    (enable),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .car_green (car_green),
        .ped_green (ped_green),
        .req_ack   (req_ack),
        .req_out   (req_out),
        .pending_l (pending_l),
        .pending_r (pending_r),
        .lockout   (lockout),
        .req_count (req_count)
    );

    assign dut_vec = {req_out, pending_l, pending_r, lockout, req_count};

    always #5 clk_10Hz = ~clk_10Hz;

    // ---------------- behavioural reference model ----------------
    typedef enum {M_IDLE, M_PENDING, M_REQ, M_WAIT, M_GREEN, M_LOCK} mstate_t;
    mstate_t    m_st;
    logic [1:0] m_meta, m_sync;
    int         m_run [2];
    logic       m_pl, m_pr, m_req, m_lock;
    int         m_cnt, m_left;

    function automatic void model_reset();
        m_st = M_IDLE; m_meta = '0; m_sync = '0;
        m_run[0] = 0; m_run[1] = 0;
        m_pl = 0; m_pr = 0; m_req = 0; m_lock = 0;
        m_cnt = 0; m_left = 0;
    endfunction

    function automatic void model_step();
        logic [1:0] seen;
        logic [1:0] ok;
        logic       had;
        mstate_t    nx;
        seen = m_sync;
        ok   = '0;
        had  = m_pl | m_pr;
        nx   = m_st;
        m_sync = m_meta;
        m_meta = {btn_r, btn_l};
        if (!enable) begin
            m_run[0] = 0; m_run[1] = 0;
            m_st = M_IDLE; m_pl = 0; m_pr = 0; m_req = 0; m_lock = 0; m_left = 0;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (seen[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DEB && m_st != M_GREEN && !ped_green) ok[i] = 1'b1;
            end else begin
                m_run[i] = 0;
            end
        end
        case (m_st)
            M_IDLE:    if (ok != 0) nx = M_PENDING;
            M_PENDING: if (ped_green) nx = M_GREEN; else if (car_green) nx = M_REQ;
            M_REQ:     if (ped_green) nx = M_GREEN; else if (req_ack) nx = M_WAIT;
                       else if (!car_green) nx = M_PENDING;
            M_WAIT:    if (ped_green) nx = M_GREEN;
            M_GREEN:   if (!ped_green) begin
                           nx = M_LOCK; m_left = LOCK;
                           if (m_cnt < 255) m_cnt = m_cnt + 1;
                       end
            M_LOCK:    if (m_left == 1) nx = (had || ok != 0) ? M_PENDING : M_IDLE;
                       else m_left = m_left - 1;
            default:   nx = M_IDLE;
        endcase
        if (ped_green) begin
            m_pl = 0; m_pr = 0;
        end else begin
            m_pl = m_pl | ok[0]; m_pr = m_pr | ok[1];
        end
        m_st   = nx;
        m_req  = (nx == M_REQ);
        m_lock = (nx == M_LOCK);
    endfunction

    function automatic logic [11:0] model_vec();
        return {m_req, m_pl, m_pr, m_lock, 8'(m_cnt)};
    endfunction

    task automatic tick();
        @(posedge clk_10Hz);
        if (!rst_n) model_reset(); else model_step();
        cyc++;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_reset();
        btn_r = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if (dut_vec !== 12'h000) begin
            n_fail++; $display("FAIL reset_state: got %03h expected 000", dut_vec);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e == 4) begin
                n_checks++;
                if (pending_r !== 1'b0) begin
                    n_fail++; $display("FAIL post_reset_edge4_pending_r: got %b expected 0", pending_r);
                end
            end
            if (e == 5) begin
                n_checks++;
                if (pending_r !== 1'b1) begin
                    n_fail++; $display("FAIL post_reset_edge5_pending_r: got %b expected 1", pending_r);
                end
            end
        end
        btn_r  = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        tick();
        n_checks++;
        if (dut_vec !== model_vec() || pending_r !== 1'b0) begin
            n_fail++; $display("FAIL reset_cleanup: got %03h expected %03h", dut_vec, model_vec());
        end
    endtask

    task automatic test_short_press();
        int seen_pl = 0, seen_req = 0;
        car_green = 1'b1;
        btn_l = 1'b1;
        tick(); tick();
        btn_l = 1'b0;
        repeat (8) begin
            tick();
            if (pending_l) seen_pl++;
            if (req_out) seen_req++;
        end
        n_checks++;
        if (seen_pl != 0 || seen_req != 0) begin
            n_fail++; $display("FAIL short_press: pending_l cycles %0d req_out cycles %0d expected 0 0", seen_pl, seen_req);
        end
        car_green = 1'b0;
        tick();
    endtask

    task automatic test_basic_cycle();
        btn_r = 1'b1;
        car_green = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            case (e)
                4: begin
                    n_checks++;
                    if (pending_r !== 1'b0) begin
                        n_fail++; $display("FAIL edge4_pending_r: got %b expected 0", pending_r);
                    end
                end
                5: begin
                    n_checks++;
                    if (pending_r !== 1'b1 || req_out !== 1'b0) begin
                        n_fail++; $display("FAIL edge5_press: pending_r %b req_out %b expected 1 0", pending_r, req_out);
                    end
                end
                6: begin
                    n_checks++;
                    if (req_out !== 1'b1) begin
                        n_fail++; $display("FAIL edge6_req_out: got %b expected 1", req_out);
                    end
                end
                9: begin
                    n_checks++;
                    if (req_out !== 1'b1) begin
                        n_fail++; $display("FAIL edge9_req_out: got %b expected 1", req_out);
                    end
                    req_ack = 1'b1;
                end
                10: begin
                    n_checks++;
                    if (req_out !== 1'b0) begin
                        n_fail++; $display("FAIL edge10_ack_drop: got %b expected 0", req_out);
                    end
                    req_ack = 1'b0;
                end
                11: ped_green = 1'b1;
                12: begin
                    n_checks++;
                    if (pending_r !== 1'b0 || lockout !== 1'b0) begin
                        n_fail++; $display("FAIL green_clear: pending_r %b lockout %b expected 0 0", pending_r, lockout);
                    end
                    ped_green = 1'b0;
                end
                13: begin
                    n_checks++;
                    if (lockout !== 1'b1 || req_count !== 8'd1) begin
                        n_fail++; $display("FAIL lockout_entry: lockout %b req_count %0d expected 1 1", lockout, req_count);
                    end
                    lock_entry = cyc;
                end
                20: btn_r = 1'b0;
                default: ;
            endcase
        end
        n_checks++;
        if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL basic_vs_model: got %03h expected %03h", dut_vec, model_vec());
        end
    endtask

    task automatic test_lockout_press();
        int guard = 0, req_hi = 0;
        repeat (10) tick();
        btn_l = 1'b1;
        repeat (DEB + 2) tick();
        btn_l = 1'b0;
        n_checks++;
        if (pending_l !== 1'b1 || lockout !== 1'b1 || req_out !== 1'b0) begin
            n_fail++; $display("FAIL lockout_latch: pl %b lockout %b req_out %b expected 1 1 0", pending_l, lockout, req_out);
        end
        while (lockout === 1'b1 && guard < 300) begin
            if (req_out) req_hi++;
            tick();
            guard++;
        end
        n_checks++;
        if (lockout !== 1'b0 || (cyc - lock_entry) != LOCK) begin
            n_fail++; $display("FAIL lockout_length: cycles %0d expected %0d", cyc - lock_entry, LOCK);
        end
        n_checks++;
        if (req_hi != 0 || pending_l !== 1'b1 || req_out !== 1'b0) begin
            n_fail++; $display("FAIL lockout_exit: req_hi %0d pl %b req_out %b expected 0 1 0", req_hi, pending_l, req_out);
        end
        tick();
        n_checks++;
        if (req_out !== 1'b1) begin
            n_fail++; $display("FAIL req_after_lockout: got %b expected 1", req_out);
        end
    endtask

    task automatic test_car_green_drop();
        car_green = 1'b0;
        tick();
        n_checks++;
        if (req_out !== 1'b0 || pending_l !== 1'b1) begin
            n_fail++; $display("FAIL car_drop: req_out %b pl %b expected 0 1", req_out, pending_l);
        end
        car_green = 1'b1;
        tick();
        n_checks++;
        if (req_out !== 1'b1) begin
            n_fail++; $display("FAIL car_return: got %b expected 1", req_out);
        end
    endtask

    task automatic test_enable_clear();
        enable = 1'b0;
        tick();
        n_checks++;
        if (req_out !== 1'b0 || pending_l !== 1'b0 || lockout !== 1'b0 || req_count !== 8'd1) begin
            n_fail++; $display("FAIL enable_clear: got %03h expected 001", dut_vec);
        end
        enable = 1'b1;
        car_green = 1'b0;
        tick();
        n_checks++;
        if (dut_vec !== 12'h001) begin
            n_fail++; $display("FAIL enable_resume: got %03h expected 001", dut_vec);
        end
    endtask

    task automatic test_press_with_ped_green();
        btn_l = 1'b1;
        repeat (DEB + 2) tick();
        btn_l = 1'b0;
        n_checks++;
        if (pending_l !== 1'b1) begin
            n_fail++; $display("FAIL pending_before_green: got %b expected 1", pending_l);
        end
        btn_r = 1'b1;
        repeat (DEB + 1) tick();
        ped_green = 1'b1;
        tick();
        n_checks++;
        if (pending_l !== 1'b0 || pending_r !== 1'b0 || req_out !== 1'b0) begin
            n_fail++; $display("FAIL press_on_green: pl %b pr %b req_out %b expected 0 0 0", pending_l, pending_r, req_out);
        end
        btn_r = 1'b0;
        ped_green = 1'b0;
        tick();
        n_checks++;
        if (lockout !== 1'b1 || req_count !== 8'd2 || pending_r !== 1'b0) begin
            n_fail++; $display("FAIL green_to_lockout: lockout %b count %0d pr %b expected 1 2 0", lockout, req_count, pending_r);
        end
        repeat (LOCK) tick();
        n_checks++;
        if (dut_vec !== 12'h002) begin
            n_fail++; $display("FAIL lockout_to_idle: got %03h expected 002", dut_vec);
        end
    endtask

    task automatic test_saturation_and_reset();
        int exp_cnt = m_cnt;
        for (int i = 0; i < 256; i++) begin
            btn_l = 1'b1;
            repeat (DEB + 2) tick();
            btn_l = 1'b0;
            ped_green = 1'b1;
            tick();
            ped_green = 1'b0;
            tick();
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            n_checks++;
            if (req_count !== 8'(exp_cnt) || lockout !== 1'b1) begin
                n_fail++; $display("FAIL serve_%0d: count %0d lockout %b expected %0d 1", i, req_count, lockout, exp_cnt);
            end
            if (i < 255) repeat (LOCK) tick();
        end
        repeat (10) tick();
        n_checks++;
        if (req_count !== 8'd255 || lockout !== 1'b1) begin
            n_fail++; $display("FAIL saturated: count %0d lockout %b expected 255 1", req_count, lockout);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec !== 12'h000) begin
            n_fail++; $display("FAIL reset_mid_lockout: got %03h expected 000", dut_vec);
        end
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0)   btn_l = ~btn_l;
            if ($urandom_range(7) == 0)   btn_r = ~btn_r;
            if ($urandom_range(9) == 0)   car_green = ~car_green;
            if ($urandom_range(29) == 0)  ped_green = ~ped_green;
            req_ack = ($urandom_range(3) == 0);
            enable  = ($urandom_range(199) != 0);
            tick();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL random_cycle_%0d: got %03h expected %03h", c, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_short_press();
        test_basic_cycle();
        test_lockout_press();
        test_car_green_drop();
        test_enable_clear();
        test_press_with_ped_green();
        test_saturation_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
